// File: rtl/score_frame_loader_pkg.sv
// Shared types and sizes for the score frame loader and the ranking stage.
package score_frame_loader_pkg;

    localparam int N_STU   = 7;
    localparam int SCORE_W = 4;
    localparam int OPT_W   = 3;
    localparam int A_W     = 2;
    localparam int B_W     = 3;
    localparam int CNT_W   = $clog2(N_STU);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_STU - 1);

    // One parallel frame: slot k of scores at bits [k*SCORE_W +: SCORE_W].
    typedef struct packed {
        logic [N_STU*SCORE_W-1:0] scores;
        logic [OPT_W-1:0]         opt;
        logic [A_W-1:0]           a;
        logic [B_W-1:0]           b;
    } frame_t;

    // Low bit position of a slot inside the packed score vector.
    function automatic int slot_lo(input logic [CNT_W-1:0] slot);
        return int'(slot) * SCORE_W;
    endfunction

endpackage

// File: rtl/score_frame_loader.sv
// Packs seven 4-bit score beats into one frame. A shadow frame collects the
// incoming beats while the output register holds the previous frame for the
// ranking stage, so the next frame can load without waiting on downstream.
module score_frame_loader
    import score_frame_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic [SCORE_W-1:0]       in_score,
    input  logic [OPT_W-1:0]         in_opt,
    input  logic [A_W-1:0]           in_a,
    input  logic [B_W-1:0]           in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_STU*SCORE_W-1:0] out_scores,
    output logic [OPT_W-1:0]         out_opt,
    output logic [A_W-1:0]           out_a,
    output logic [B_W-1:0]           out_b,
    output logic                     frame_err
);

    logic [CNT_W-1:0] cnt;
    frame_t           frame_p0;
    logic             vld_p0;
    frame_t           frame_p1;
    logic             vld_p1;
    logic             in_ready_r;
    logic             frame_err_r;

    logic             accept;
    logic             transfer;
    logic             last_beat;
    logic             vld_p0_nxt;

    // in_ready is a register equal to !vld_p0, so accept and transfer are exclusive.
    assign accept     = in_valid && in_ready_r;
    assign transfer   = vld_p0 && (!vld_p1 || out_ready);
    assign last_beat  = accept && !in_first && (cnt == LAST_SLOT);
    assign vld_p0_nxt = transfer ? 1'b0 : (last_beat ? 1'b1 : vld_p0);

    // Stage p0: beat collection into the shadow frame, framing checks, in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            frame_p0    <= '0;
            vld_p0      <= 1'b0;
            in_ready_r  <= 1'b1;
            frame_err_r <= 1'b0;
        end else begin
            vld_p0      <= vld_p0_nxt;
            in_ready_r  <= !vld_p0_nxt;
            frame_err_r <= 1'b0;
            if (accept) begin
                if (in_first) begin
                    // A first beat always restarts the frame; any partial is abandoned.
                    frame_p0.scores[slot_lo('0) +: SCORE_W] <= in_score;
                    frame_p0.opt <= in_opt;
                    frame_p0.a   <= in_a;
                    frame_p0.b   <= in_b;
                    cnt          <= CNT_W'(1);
                    frame_err_r  <= (cnt != '0);
                end else if (cnt == '0) begin
                    // Continuation beat with no frame open: dropped.
                    frame_err_r  <= 1'b1;
                end else begin
                    frame_p0.scores[slot_lo(cnt) +: SCORE_W] <= in_score;
                    cnt <= (cnt == LAST_SLOT) ? '0 : cnt + 1'b1;
                end
            end
        end
    end

    // Stage p1: output register acting as a one-entry skid toward the ranking stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (transfer) begin
            frame_p1 <= frame_p0;
            vld_p1   <= 1'b1;
        end else if (vld_p1 && out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign in_ready   = in_ready_r;
    assign frame_err  = frame_err_r;
    assign out_valid  = vld_p1;
    assign out_scores = frame_p1.scores;
    assign out_opt    = frame_p1.opt;
    assign out_a      = frame_p1.a;
    assign out_b      = frame_p1.b;

endmodule

// File: tb/tb_score_frame_loader.sv
// Bench for score_frame_loader: directed scenarios plus randomized traffic,
// checked against a beat-list model of the framing rules.
module tb_score_frame_loader;
    import score_frame_loader_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_first;
    logic [SCORE_W-1:0]       in_score;
    logic [OPT_W-1:0]         in_opt;
    logic [A_W-1:0]           in_a;
    logic [B_W-1:0]           in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_STU*SCORE_W-1:0] out_scores;
    logic [OPT_W-1:0]         out_opt;
    logic [A_W-1:0]           out_a;
    logic [B_W-1:0]           out_b;
    logic                     frame_err;

    score_frame_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_score   (in_score),
        .in_opt     (in_opt),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_scores (out_scores),
        .out_opt    (out_opt),
        .out_a      (out_a),
        .out_b      (out_b),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_STU*SCORE_W-1:0] scores;
        logic [OPT_W-1:0]         opt;
        logic [A_W-1:0]           a;
        logic [B_W-1:0]           b;
    } exp_frame_t;

    // Reference model state: open beats of the current frame and finished frames.
    logic [SCORE_W-1:0] part[$];
    logic [OPT_W-1:0]   p_opt;
    logic [A_W-1:0]     p_a;
    logic [B_W-1:0]     p_b;
    exp_frame_t         exp_q[$];
    logic               exp_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_count = 0;
    int last_hs_cyc = 0;
    int prev_hs_cyc = 0;
    int stall_cnt = 0;
    logic [N_STU*SCORE_W-1:0] last_out_scores;

    logic obs_acc, obs_vld, obs_rdy, obs_err;
    logic hold_prev;
    logic [N_STU*SCORE_W-1:0] prev_sc;
    logic [OPT_W-1:0] prev_o;
    logic [A_W-1:0]   prev_a;
    logic [B_W-1:0]   prev_b;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        exp_q.delete();
        exp_err   = 1'b0;
        hold_prev = 1'b0;
    endtask

    // One cycle: check what the previous edge produced, drive inputs, update model.
    task automatic step(input logic v, input logic f, input logic [SCORE_W-1:0] s,
                        input logic [OPT_W-1:0] o, input logic [A_W-1:0] a,
                        input logic [B_W-1:0] b, input logic ordy);
        exp_frame_t ef;
        @(negedge clk);
        cyc++;
        check("frame_err", frame_err, exp_err);
        obs_err = frame_err;
        if (hold_prev)
            check("hold_stable", {out_valid, out_scores, out_opt, out_a, out_b},
                  {1'b1, prev_sc, prev_o, prev_a, prev_b});
        in_valid = v; in_first = f; in_score = s; in_opt = o; in_a = a; in_b = b;
        out_ready = ordy;
        obs_vld = out_valid;
        obs_rdy = in_ready;
        obs_acc = v && in_ready;
        if (out_valid && ordy) begin
            hs_count++;
            prev_hs_cyc = last_hs_cyc;
            last_hs_cyc = cyc;
            last_out_scores = out_scores;
            if (exp_q.size() == 0) begin
                check("hs_unexpected", 1, 0);
            end else begin
                ef = exp_q.pop_front();
                check("out_frame", {out_scores, out_opt, out_a, out_b},
                      {ef.scores, ef.opt, ef.a, ef.b});
            end
        end
        hold_prev = out_valid && !ordy;
        prev_sc = out_scores; prev_o = out_opt; prev_a = out_a; prev_b = out_b;
        exp_err = 1'b0;
        if (obs_acc) begin
            if (f) begin
                exp_err = (part.size() != 0);
                part.delete();
                part.push_back(s);
                p_opt = o; p_a = a; p_b = b;
            end else if (part.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                part.push_back(s);
                if (part.size() == N_STU) begin
                    for (int k = 0; k < N_STU; k++)
                        ef.scores[k*SCORE_W +: SCORE_W] = part[k];
                    ef.opt = p_opt; ef.a = p_a; ef.b = p_b;
                    exp_q.push_back(ef);
                    part.delete();
                end
            end
        end
    endtask

    task automatic send_beat(input logic f, input logic [SCORE_W-1:0] s,
                             input logic [OPT_W-1:0] o, input logic [A_W-1:0] a,
                             input logic [B_W-1:0] b, input logic ordy);
        int n = 0;
        do begin
            step(1'b1, f, s, o, a, b, ordy);
            if (!obs_acc) stall_cnt++;
            n++;
        end while (!obs_acc && n < 64);
        if (!obs_acc) check("beat_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [N_STU*SCORE_W-1:0] sc, input logic [OPT_W-1:0] o,
                              input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                              input logic ordy);
        for (int k = 0; k < N_STU; k++)
            send_beat(k == 0, sc[k*SCORE_W +: SCORE_W], o, a, b, ordy);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, '0, '0, '0, '0, ordy);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            idle(1'b1);
            n++;
        end
        if (n >= 100) check("drain_timeout", n, 0);
    endtask

    initial begin
        int hs0;
        int gidx;
        logic v, f, ordy;

        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_score = '0;
        in_opt = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_out_data", {out_scores, out_opt, out_a, out_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: single frame, latency and content.
        send_frame(28'h7654321, 3'b011, 2'd1, 3'd2, 1'b1);
        idle(1'b1);
        check("t1_bubble_valid", obs_vld, 0);
        check("t1_bubble_ready", obs_rdy, 0);
        idle(1'b1);
        check("t1_out_valid", obs_vld, 1);
        check("t1_out_scores", last_out_scores, 28'h7654321);
        check("t1_out_cfg", {out_opt, out_a, out_b}, {3'b011, 2'd1, 3'd2});
        drain();

        // Scenario 2: back-to-back frames, one bubble, outputs 8 cycles apart.
        stall_cnt = 0;
        send_frame(28'h1357ace, 3'd5, 2'd3, 3'd7, 1'b1);
        send_frame(28'hfdb9753, 3'd2, 2'd0, 3'd1, 1'b1);
        check("t2_stalls", stall_cnt, 1);
        drain();
        check("t2_out_spacing", last_hs_cyc - prev_hs_cyc, 8);

        // Scenario 3: downstream stalled with two frames; in order release.
        send_frame(28'h1111111, 3'd1, 2'd1, 3'd1, 1'b0);
        send_frame(28'h2222222, 3'd2, 2'd2, 3'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 4'hf, 3'd7, 2'd3, 3'd7, 1'b0);
            check("t3_in_ready_low", obs_rdy, 0);
        end
        hs0 = hs_count;
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("t3_two_frames_out", hs_count - hs0, 2);
        check("t3_last_frame", last_out_scores, 28'h2222222);
        drain();

        // Scenario 4: restart mid-frame.
        for (int k = 0; k < 4; k++) send_beat(k == 0, 4'(k + 1), 3'd1, 2'd1, 3'd1, 1'b1);
        send_beat(1'b1, 4'h9, 3'd5, 2'd2, 3'd6, 1'b1);
        idle(1'b1);
        check("t4_frame_err", obs_err, 1);
        for (int k = 0; k < 6; k++) send_beat(1'b0, 4'(10 + k), 3'd0, 2'd0, 3'd0, 1'b1);
        drain();
        check("t4_new_frame", last_out_scores, 28'hfedcba9);
        check("t4_new_cfg", {out_opt, out_a, out_b}, {3'd5, 2'd2, 3'd6});

        // Scenario 5: orphan continuation beat.
        send_beat(1'b0, 4'h5, 3'd0, 2'd0, 3'd0, 1'b1);
        idle(1'b1);
        check("t5_frame_err", obs_err, 1);
        send_frame(28'h0a0b0c0, 3'd4, 2'd1, 3'd3, 1'b1);
        drain();
        check("t5_clean_frame", last_out_scores, 28'h0a0b0c0);

        // Scenario 6: reset with a held frame and a partial frame.
        send_frame(28'h3333333, 3'd3, 2'd3, 3'd3, 1'b0);
        for (int k = 0; k < 3; k++) send_beat(k == 0, 4'hc, 3'd1, 2'd1, 3'd1, 1'b0);
        idle(1'b0);
        check("t6_held_valid", obs_vld, 1);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_out_data", out_scores, 0);
        model_reset();
        #2 rst_n = 1'b1;
        send_frame(28'h4455667, 3'd6, 2'd2, 3'd4, 1'b1);
        drain();
        check("t6_after_reset", last_out_scores, 28'h4455667);

        // Randomized traffic with occasional framing errors and backpressure.
        gidx = 0;
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom % 4) != 0;
            f    = (gidx == 0);
            if (($urandom % 16) == 0) f = ~f;
            ordy = ($urandom % 3) != 0;
            step(v, f, 4'($urandom), 3'($urandom), 2'($urandom), 3'($urandom), ordy);
            if (obs_acc) begin
                if (f) gidx = 1;
                else if (gidx != 0) gidx = (gidx == N_STU - 1) ? 0 : gidx + 1;
            end
        end
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
